// File: rtl/facelet_mem_arbiter_if.sv
// Bus between the VGA timing/renderer, the cube-move engine, the facelet RAM and
// facelet_mem_arbiter.
interface facelet_mem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 3
);
  logic [9:0]        hc;
  logic [9:0]        vc;
  logic              disp_valid;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_dvalid;
  logic              upd_req;
  logic              upd_we;
  logic [ADDR_W-1:0] upd_addr;
  logic [DATA_W-1:0] upd_wdata;
  logic              upd_gnt;
  logic [DATA_W-1:0] upd_rdata;
  logic              upd_rvalid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              vblank_start;
  logic              err_oob;
  logic [1:0]        dbg_state;

  // Handshake: disp_valid is never back-pressured. An update transfers in the cycle
  // where upd_req && upd_gnt. Until then the requester holds upd_req, upd_we,
  // upd_addr and upd_wdata stable. Read data returns one cycle later with its rvalid.
  modport slave (
    input  hc, vc, disp_valid, disp_addr, upd_req, upd_we, upd_addr, upd_wdata, mem_rdata,
    output disp_data, disp_dvalid, upd_gnt, upd_rdata, upd_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata, vblank_start, err_oob, dbg_state
  );

  modport master (
    output hc, vc, disp_valid, disp_addr, upd_req, upd_we, upd_addr, upd_wdata, mem_rdata,
    input  disp_data, disp_dvalid, upd_gnt, upd_rdata, upd_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata, vblank_start, err_oob, dbg_state
  );
endinterface

// File: rtl/facelet_mem_arbiter.sv
// Shares the single-port facelet colour RAM. Display reads always win. Move-engine
// accesses are granted only outside the active-video window, in bursts of up to
// MAX_BURST.
module facelet_mem_arbiter #(
  parameter int DEPTH     = 54,
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 3,
  parameter int HBP       = 144,
  parameter int HFP       = 784,
  parameter int VBP       = 31,
  parameter int VFP       = 511,
  parameter int MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  facelet_mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [9:0] WIN_H0 = 10'(HBP - 2);
  localparam logic [9:0] WIN_H1 = 10'(HFP);
  localparam logic [9:0] WIN_V0 = 10'(VBP);
  localparam logic [9:0] WIN_V1 = 10'(VFP);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {LOCKED = 2'd0, OPEN = 2'd1, COOL = 2'd2} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] burst_q;
  logic             win, gnt, disp_oob, upd_oob;
  logic             disp_rd_q, disp_oob_q, upd_rd_q, upd_oob_q, vblank_q, err_q;

  // Window opens two pixels early so the renderer's prefetch is already protected.
  assign win = (bus.vc >= WIN_V0) && (bus.vc < WIN_V1) &&
               (bus.hc >= WIN_H0) && (bus.hc < WIN_H1);

  assign disp_oob = {1'b0, bus.disp_addr} >= DEPTH_C;
  assign upd_oob  = {1'b0, bus.upd_addr} >= DEPTH_C;
  assign gnt      = bus.upd_req && (state_q == OPEN) && !win && !bus.disp_valid;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (clr) begin
      bus.mem_en = 1'b0;
    end else if (bus.disp_valid) begin
      if (!disp_oob) begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.disp_addr;
      end
    end else if (gnt && !upd_oob) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.upd_we;
      bus.mem_addr  = bus.upd_addr;
      bus.mem_wdata = bus.upd_wdata;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= LOCKED;
      burst_q <= '0;
    end else begin
      unique case (state_q)
        LOCKED: begin
          burst_q <= '0;
          if (!win) state_q <= OPEN;
        end
        OPEN: begin
          if (win) begin
            state_q <= LOCKED;
            burst_q <= '0;
          end else if (gnt) begin
            if (burst_q == LAST_CNT) begin
              state_q <= COOL;
              burst_q <= '0;
            end else begin
              burst_q <= burst_q + 1'b1;
            end
          end else begin
            burst_q <= '0;
          end
        end
        COOL: begin
          burst_q <= '0;
          state_q <= win ? LOCKED : OPEN;
        end
        default: begin
          state_q <= LOCKED;
          burst_q <= '0;
        end
      endcase
    end
  end

  // Out-of-range reads still return a valid beat, but with forced-zero data.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      disp_rd_q  <= 1'b0;
      disp_oob_q <= 1'b0;
      upd_rd_q   <= 1'b0;
      upd_oob_q  <= 1'b0;
      vblank_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      disp_rd_q  <= bus.disp_valid;
      disp_oob_q <= bus.disp_valid && disp_oob;
      upd_rd_q   <= gnt && !bus.upd_we;
      upd_oob_q  <= gnt && !bus.upd_we && upd_oob;
      vblank_q   <= (bus.vc == WIN_V1) && (bus.hc == 10'd0);
      if ((bus.disp_valid && disp_oob) || (gnt && upd_oob)) err_q <= 1'b1;
    end
  end

  assign bus.upd_gnt      = gnt;
  assign bus.disp_dvalid  = disp_rd_q;
  assign bus.disp_data    = (disp_rd_q && !disp_oob_q) ? bus.mem_rdata : '0;
  assign bus.upd_rvalid   = upd_rd_q;
  assign bus.upd_rdata    = (upd_rd_q && !upd_oob_q) ? bus.mem_rdata : '0;
  assign bus.vblank_start = vblank_q;
  assign bus.err_oob      = err_q;
  assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_facelet_mem_arbiter.sv
// Bench for facelet_mem_arbiter: directed vectors plus random traffic checked against
// a grant-history / shadow-RAM reference model.
module tb_facelet_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 3;
  localparam int DEPTH = 54;
  localparam int MAXB = 8;

  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   errors = 0;

  facelet_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  facelet_mem_arbiter dut (.clk(clk), .clr(clr), .bus(bus.slave));

  always #5 clk = ~clk;

  // Facelet RAM: synchronous read, one cycle of latency.
  logic [DW-1:0] ram [64] = '{default: '0};
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else ram_q <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = ram_q;

  // Reference model state
  logic [DW-1:0] shadow [64] = '{default: '0};
  logic [DW-1:0] exp_q[$];
  bit m_fresh, m_prev_win, m_dv, m_uv, m_vb, m_err;
  int m_run;
  bit e_gnt, e_en, e_we, s_win;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic s_gnt, s_en, s_dvalid, s_err, s_vb;
  logic [DW-1:0] s_ddata;

  typedef struct {
    logic [9:0] hc; logic [9:0] vc; logic dv; logic [AW-1:0] daddr;
    logic req; logic we; logic [AW-1:0] uaddr; logic [DW-1:0] wd;
    logic x_gnt; logic x_en; logic x_we; logic [AW-1:0] x_addr;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit win_of(input int h, input int v);
    return (v >= 31) && (v < 511) && (h >= 142) && (h < 784);
  endfunction

  task automatic set_in(input int h, input int v, input bit dv, input int da,
                        input bit rq, input bit we, input int ua, input int wd);
    bus.hc = 10'(h); bus.vc = 10'(v); bus.disp_valid = dv; bus.disp_addr = AW'(da);
    bus.upd_req = rq; bus.upd_we = we; bus.upd_addr = AW'(ua); bus.upd_wdata = DW'(wd);
  endtask

  task automatic model_reset();
    m_fresh = 1; m_prev_win = 1; m_run = 0;
    m_dv = 0; m_uv = 0; m_vb = 0; m_err = 0;
    exp_q.delete();
  endtask

  task automatic check_cycle();
    bit open;
    logic [DW-1:0] d;
    s_win = win_of(int'(bus.hc), int'(bus.vc));
    // Grants only when the previous cycle was outside the window, no burst of MAXB just ended.
    open  = !m_fresh && !m_prev_win && (m_run < MAXB);
    e_gnt = bus.upd_req && open && !s_win && !bus.disp_valid;
    e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    if (bus.disp_valid) begin
      if (int'(bus.disp_addr) < DEPTH) begin e_en = 1; e_addr = bus.disp_addr; end
    end else if (e_gnt && int'(bus.upd_addr) < DEPTH) begin
      e_en = 1; e_we = bus.upd_we; e_addr = bus.upd_addr; e_wdata = bus.upd_wdata;
    end
    s_gnt = bus.upd_gnt; s_en = bus.mem_en; s_dvalid = bus.disp_dvalid;
    s_ddata = bus.disp_data; s_err = bus.err_oob; s_vb = bus.vblank_start;
    chk("upd_gnt", 32'(bus.upd_gnt), 32'(e_gnt));
    chk("mem_en", 32'(bus.mem_en), 32'(e_en));
    chk("mem_we", 32'(bus.mem_we), 32'(e_we));
    if (e_en) chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    if (e_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
    chk("disp_dvalid", 32'(bus.disp_dvalid), 32'(m_dv));
    chk("upd_rvalid", 32'(bus.upd_rvalid), 32'(m_uv));
    chk("vblank_start", 32'(bus.vblank_start), 32'(m_vb));
    chk("err_oob", 32'(bus.err_oob), 32'(m_err));
    d = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    chk("disp_data", 32'(bus.disp_data), m_dv ? 32'(d) : 32'd0);
    chk("upd_rdata", 32'(bus.upd_rdata), m_uv ? 32'(d) : 32'd0);
  endtask

  task automatic advance();
    bit d_oob, u_oob;
    d_oob = int'(bus.disp_addr) >= DEPTH;
    u_oob = int'(bus.upd_addr) >= DEPTH;
    if (bus.disp_valid) exp_q.push_back(d_oob ? '0 : shadow[bus.disp_addr]);
    else if (e_gnt && !bus.upd_we) exp_q.push_back(u_oob ? '0 : shadow[bus.upd_addr]);
    if (e_gnt && bus.upd_we && !u_oob) shadow[bus.upd_addr] = bus.upd_wdata;
    m_dv = bus.disp_valid;
    m_uv = e_gnt && !bus.upd_we;
    if ((bus.disp_valid && d_oob) || (e_gnt && u_oob)) m_err = 1;
    m_vb = (bus.vc == 10'd511) && (bus.hc == 10'd0);
    m_run = e_gnt ? m_run + 1 : 0;
    m_prev_win = s_win;
    m_fresh = 0;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk); #1;
    advance();
  endtask

  task automatic do_reset(input int n);
    clr = 1'b1;
    model_reset();
    repeat (n) begin
      @(negedge clk);
      chk("rst_upd_gnt", 32'(bus.upd_gnt), 0);
      chk("rst_mem_en", 32'(bus.mem_en), 0);
      chk("rst_mem_we", 32'(bus.mem_we), 0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 0);
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
      chk("rst_disp", 32'({bus.disp_dvalid, bus.disp_data}), 0);
      chk("rst_upd_rd", 32'({bus.upd_rvalid, bus.upd_rdata}), 0);
      chk("rst_vblank", 32'(bus.vblank_start), 0);
      chk("rst_err_oob", 32'(bus.err_oob), 0);
      @(posedge clk); #1;
    end
    clr = 1'b0;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 1, 0, 1, 0);
    do_reset(3);
    step();                       // state leaves LOCKED on this edge
    step();
    chk("post_rst_gnt", 32'(s_gnt), 1);

    // Window edge sweep and preemption, table-driven
    for (int i = 0; i < 11; i++)
      tbl.push_back('{hc: 10'(140 + i), vc: 10'd100, dv: 1'b0, daddr: '0, req: 1'b1, we: 1'b1,
                      uaddr: AW'(20 + i), wd: DW'(i), x_gnt: (i < 2), x_en: (i < 2),
                      x_we: (i < 2), x_addr: AW'(20 + i)});
    tbl.push_back('{hc: 0,   vc: 0,   dv: 0, daddr: 0, req: 1, we: 1, uaddr: 9, wd: 1, x_gnt: 0, x_en: 0, x_we: 0, x_addr: 0});
    tbl.push_back('{hc: 10,  vc: 0,   dv: 1, daddr: 7, req: 1, we: 1, uaddr: 9, wd: 6, x_gnt: 0, x_en: 1, x_we: 0, x_addr: 7});
    tbl.push_back('{hc: 11,  vc: 0,   dv: 0, daddr: 7, req: 1, we: 1, uaddr: 9, wd: 6, x_gnt: 1, x_en: 1, x_we: 1, x_addr: 9});
    tbl.push_back('{hc: 783, vc: 100, dv: 0, daddr: 0, req: 1, we: 0, uaddr: 2, wd: 0, x_gnt: 0, x_en: 0, x_we: 0, x_addr: 0});
    tbl.push_back('{hc: 784, vc: 100, dv: 0, daddr: 0, req: 1, we: 0, uaddr: 2, wd: 0, x_gnt: 0, x_en: 0, x_we: 0, x_addr: 0});
    tbl.push_back('{hc: 785, vc: 100, dv: 0, daddr: 0, req: 1, we: 0, uaddr: 2, wd: 0, x_gnt: 1, x_en: 1, x_we: 0, x_addr: 2});
    tbl.push_back('{hc: 200, vc: 30,  dv: 0, daddr: 0, req: 1, we: 0, uaddr: 3, wd: 0, x_gnt: 1, x_en: 1, x_we: 0, x_addr: 3});
    tbl.push_back('{hc: 200, vc: 31,  dv: 0, daddr: 0, req: 1, we: 0, uaddr: 3, wd: 0, x_gnt: 0, x_en: 0, x_we: 0, x_addr: 0});
    tbl.push_back('{hc: 0,   vc: 511, dv: 0, daddr: 0, req: 0, we: 0, uaddr: 0, wd: 0, x_gnt: 0, x_en: 0, x_we: 0, x_addr: 0});
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    foreach (tbl[k]) begin
      set_in(int'(tbl[k].hc), int'(tbl[k].vc), tbl[k].dv, int'(tbl[k].daddr), tbl[k].req,
             tbl[k].we, int'(tbl[k].uaddr), int'(tbl[k].wd));
      @(negedge clk);
      chk("tbl_gnt", 32'(bus.upd_gnt), 32'(tbl[k].x_gnt));
      chk("tbl_en", 32'(bus.mem_en), 32'(tbl[k].x_en));
      chk("tbl_we", 32'(bus.mem_we), 32'(tbl[k].x_we));
      if (tbl[k].x_en) chk("tbl_addr", 32'(bus.mem_addr), 32'(tbl[k].x_addr));
      check_cycle();
      @(posedge clk); #1;
      advance();
    end
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("vblank_pulse", 32'(s_vb), 1);

    // Held burst request: eight grants, one cool cycle, repeat
    begin
      int a;
      a = 0;
      for (int c = 1; c <= 20; c++) begin
        set_in(0, 0, 0, 0, 1, 1, a, a);
        step();
        chk("burst_gnt", 32'(s_gnt), 32'((c % 9) != 0));
        if (s_gnt) a++;
      end
    end

    // Write then display read-back
    set_in(0, 0, 0, 0, 1, 1, 5, 5);
    step();
    chk("wr5_gnt", 32'(s_gnt), 1);
    set_in(0, 0, 1, 5, 0, 0, 0, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("rd5_dvalid", 32'(s_dvalid), 1);
    chk("rd5_data", 32'(s_ddata), 32'd5);

    // Out-of-range write: grant consumed, RAM untouched, sticky error
    set_in(0, 0, 0, 0, 1, 1, 54, 7);
    step();
    chk("oob_gnt", 32'(s_gnt), 1);
    chk("oob_mem_en", 32'(s_en), 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) begin
      step();
      chk("oob_sticky", 32'(s_err), 1);
    end
    do_reset(2);
    step();
    chk("oob_cleared", 32'(s_err), 0);

    // Reset while a granted read is in flight
    set_in(0, 0, 0, 0, 1, 0, 3, 0);
    step();
    chk("mid_rd_gnt", 32'(s_gnt), 1);
    set_in(0, 0, 0, 0, 1, 1, 4, 2);
    do_reset(2);
    step();
    step();

    // Random traffic against the reference model
    for (int n = 0; n < 1500; n++) begin
      int h, v;
      case ($urandom_range(0, 3))
        0: h = $urandom_range(138, 146);
        1: h = $urandom_range(780, 788);
        default: h = $urandom_range(0, 799);
      endcase
      case ($urandom_range(0, 4))
        0: v = $urandom_range(28, 34);
        1: v = $urandom_range(508, 513);
        2: v = $urandom_range(31, 510);
        default: v = $urandom_range(511, 524);
      endcase
      set_in(h, v, $urandom_range(0, 3) == 0, $urandom_range(0, 59), $urandom_range(0, 9) < 7,
             $urandom_range(0, 1) == 1, $urandom_range(0, 59), $urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) do_reset(1);
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
